// File: rtl/axi_rd_scheduler_if.sv
// Signal bundle between the read scheduler and the crossbar datapath.
// Port names match the crossbar's read-path control naming.
interface axi_rd_scheduler_if;
  // AR/R handshakes follow AXI rules: a transfer happens on a rising edge
  // where both valid and ready are high, and a valid, once raised, is held
  // until that transfer. The scheduler only observes these signals.
  logic        arvalid_m0_i;
  logic [31:0] araddr_m0_i;
  logic [3:0]  arlen_m0_i;
  logic        arvalid_m1_i;
  logic [31:0] araddr_m1_i;
  logic [3:0]  arlen_m1_i;
  logic        arready_sel_i;
  logic        rvalid_sel_i;
  logic        rready_sel_i;
  logic        rlast_sel_i;
  logic [1:0]  grant_o;
  logic [2:0]  slv_sel_o;
  logic        ar_en_o;
  logic        busy_o;
  logic        len_err_o;
  logic        timeout_o;
  logic [1:0]  dbg_state_o;

  modport slave (
    input  arvalid_m0_i, araddr_m0_i, arlen_m0_i,
    input  arvalid_m1_i, araddr_m1_i, arlen_m1_i,
    input  arready_sel_i, rvalid_sel_i, rready_sel_i, rlast_sel_i,
    output grant_o, slv_sel_o, ar_en_o, busy_o, len_err_o, timeout_o,
    output dbg_state_o
  );

  modport master (
    output arvalid_m0_i, araddr_m0_i, arlen_m0_i,
    output arvalid_m1_i, araddr_m1_i, arlen_m1_i,
    output arready_sel_i, rvalid_sel_i, rready_sel_i, rlast_sel_i,
    input  grant_o, slv_sel_o, ar_en_o, busy_o, len_err_o, timeout_o,
    input  dbg_state_o
  );
endinterface

// File: rtl/axi_rd_scheduler.sv
// Read-path scheduler for the 2x2 AXI crossbar: round-robin AR arbitration,
// address decode, grant hold until RLAST, beat counting. Optional watchdog: AXI_RD_TIMEOUT_EN.
module axi_rd_scheduler #(
  parameter logic [31:0] S0_BASE        = 32'h0000_0000,
  parameter logic [31:0] S1_BASE        = 32'h0001_0000,
  parameter logic [31:0] WIN_MASK       = 32'hFFFF_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input logic               ACLK,
  input logic               ARESETn,
  axi_rd_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic [2:0]  r_sel, w_sel_nxt;
  logic [3:0]  r_arlen, w_arlen_nxt;
  logic [4:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic        r_rr_pri, w_rr_pri_nxt;
  logic        r_len_err, w_len_err_nxt;

  logic        w_any_req;
  logic        w_winner;
  logic [31:0] w_win_addr;
  logic [3:0]  w_win_len;
  logic        w_r_hs;
  logic [5:0]  w_beat_inc;
  logic [5:0]  w_len_target;
  logic        w_timeout_hit;

  function automatic logic [2:0] decode_slave(input logic [31:0] addr);
    if ((addr & WIN_MASK) == (S0_BASE & WIN_MASK))      return 3'b001;
    else if ((addr & WIN_MASK) == (S1_BASE & WIN_MASK)) return 3'b010;
    else                                                return 3'b100;
  endfunction

  // w_winner: 0 selects M0, 1 selects M1; rr_pri only matters on a tie.
  assign w_any_req    = bus.arvalid_m0_i | bus.arvalid_m1_i;
  assign w_winner     = (bus.arvalid_m0_i & bus.arvalid_m1_i) ? r_rr_pri : bus.arvalid_m1_i;
  assign w_win_addr   = w_winner ? bus.araddr_m1_i : bus.araddr_m0_i;
  assign w_win_len    = w_winner ? bus.arlen_m1_i  : bus.arlen_m0_i;
  assign w_r_hs       = bus.rvalid_sel_i & bus.rready_sel_i;
  assign w_beat_inc   = {1'b0, r_beat_cnt} + 6'd1;
  assign w_len_target = {2'b00, r_arlen} + 6'd1;

`ifdef AXI_RD_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_to_cnt;
  logic        r_timeout;
  logic        w_hs_any;

  assign w_hs_any = ((r_state == ST_ADDR) & bus.arready_sel_i) |
                    ((r_state == ST_DATA) & w_r_hs);
  // Fires on the last cycle of the window so the abort lands exactly TIMEOUT_CYCLES in.
  assign w_timeout_hit = (r_state != ST_IDLE) & ~w_hs_any & (r_to_cnt == TO_LIMIT);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_to_cnt  <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) || w_hs_any || w_timeout_hit) r_to_cnt <= 16'd0;
      else                                                   r_to_cnt <= r_to_cnt + 16'd1;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  assign bus.timeout_o = r_timeout;
`else
  logic [15:0] w_unused_to_limit;

  assign w_unused_to_limit = 16'(TIMEOUT_CYCLES);
  assign w_timeout_hit     = 1'b0;
  assign bus.timeout_o     = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= ST_IDLE;
      r_grant    <= 2'b00;
      r_sel      <= 3'b000;
      r_arlen    <= 4'd0;
      r_beat_cnt <= 5'd0;
      r_rr_pri   <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_sel      <= w_sel_nxt;
      r_arlen    <= w_arlen_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_rr_pri   <= w_rr_pri_nxt;
      r_len_err  <= w_len_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_sel_nxt      = r_sel;
    w_arlen_nxt    = r_arlen;
    w_beat_cnt_nxt = r_beat_cnt;
    w_rr_pri_nxt   = r_rr_pri;
    w_len_err_nxt  = r_len_err;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant_nxt = w_winner ? 2'b10 : 2'b01;
          w_sel_nxt   = decode_slave(w_win_addr);
          w_arlen_nxt = w_win_len;
          w_state_nxt = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (w_timeout_hit) begin
          w_grant_nxt  = 2'b00;
          w_sel_nxt    = 3'b000;
          w_rr_pri_nxt = r_grant[0];
          w_state_nxt  = ST_IDLE;
        end else if (bus.arready_sel_i) begin
          w_state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_timeout_hit) begin
          w_grant_nxt    = 2'b00;
          w_sel_nxt      = 3'b000;
          w_beat_cnt_nxt = 5'd0;
          w_rr_pri_nxt   = r_grant[0];
          w_state_nxt    = ST_IDLE;
        end else if (w_r_hs) begin
          if (bus.rlast_sel_i) begin
            if (w_beat_inc != w_len_target) w_len_err_nxt = 1'b1;
            w_grant_nxt    = 2'b00;
            w_sel_nxt      = 3'b000;
            w_beat_cnt_nxt = 5'd0;
            // Served M0 (grant 01) hands priority to M1, and vice versa.
            w_rr_pri_nxt   = r_grant[0];
            w_state_nxt    = ST_IDLE;
          end else begin
            // Expected final beat came without RLAST; keep waiting for it.
            if (w_beat_inc == w_len_target) w_len_err_nxt = 1'b1;
            if (r_beat_cnt != 5'd31) w_beat_cnt_nxt = w_beat_inc[4:0];
          end
        end
      end

      default: begin
        w_grant_nxt    = 2'b00;
        w_sel_nxt      = 3'b000;
        w_beat_cnt_nxt = 5'd0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  assign bus.grant_o     = r_grant;
  assign bus.slv_sel_o   = r_sel;
  assign bus.ar_en_o     = (r_state == ST_ADDR);
  assign bus.busy_o      = (r_state != ST_IDLE);
  assign bus.len_err_o   = r_len_err;
  assign bus.dbg_state_o = r_state;

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Randomized scoreboard bench for axi_rd_scheduler: a driver issues read
// transactions and queues expected grant/select/len_err; a monitor checks them.
module tb_axi_rd_scheduler;

  localparam int TO_CYC = 16;

  logic ACLK;
  logic ARESETn;

  axi_rd_scheduler_if u_if ();

  axi_rd_scheduler #(
    .S0_BASE        (32'h0000_0000),
    .S1_BASE        (32'h0001_0000),
    .WIN_MASK       (32'hFFFF_0000),
    .TIMEOUT_CYCLES (TO_CYC)
  ) u_dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (u_if)
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard state ----------------
  // exp entry: {len_err, slv_sel[2:0], grant[1:0]}
  logic [5:0] exp_q[$];
  int         n_cmp;
  int         n_err;
  bit         m_pri;   // reference: master favoured on a tie (0=M0)
  bit         m_err;   // reference: sticky length error

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_decode(input logic [31:0] a);
    if (a[31:16] == 16'h0000) return 3'b001;
    if (a[31:16] == 16'h0001) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [15:0] lo;
    lo = 16'($urandom_range(0, 65535));
    case ($urandom_range(0, 2))
      0:       return {16'h0000, lo};
      1:       return {16'h0001, lo};
      default: return {16'($urandom_range(2, 65535)), lo};
    endcase
  endfunction

  // ---------------- monitor ----------------
  logic [5:0] mon_cur;
  logic       mon_busy_q;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      mon_busy_q = 1'b0;
    end else begin
      if (u_if.busy_o && !mon_busy_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(u_if.grant_o), 32'd0);
          mon_cur = 6'd0;
        end else begin
          mon_cur = exp_q.pop_front();
          check("grant", 32'(u_if.grant_o), 32'(mon_cur[1:0]));
          check("slv_sel", 32'(u_if.slv_sel_o), 32'(mon_cur[4:2]));
          check("ar_en_first_addr_cycle", 32'(u_if.ar_en_o), 32'd1);
        end
      end else if (u_if.busy_o) begin
        check("grant_hold", 32'({u_if.slv_sel_o, u_if.grant_o}), 32'(mon_cur[4:0]));
      end else if (mon_busy_q) begin
        check("len_err_at_end", 32'(u_if.len_err_o), 32'(mon_cur[5]));
        check("release_clears", 32'({u_if.slv_sel_o, u_if.grant_o, u_if.ar_en_o}), 32'd0);
      end
      mon_busy_q = u_if.busy_o;
    end
  end

  // ---------------- driver ----------------
  task automatic clear_inputs();
    u_if.arvalid_m0_i  = 1'b0;
    u_if.arvalid_m1_i  = 1'b0;
    u_if.arready_sel_i = 1'b0;
    u_if.rvalid_sel_i  = 1'b0;
    u_if.rready_sel_i  = 1'b0;
    u_if.rlast_sel_i   = 1'b0;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      if (u_if.busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("grant_latency_bound", 32'd0, 32'd1);
  endtask

  // rlast_at=0 -> RLAST on beat arlen+1; rst_beat>0 -> reset pulse before that beat.
  task automatic run_txn(input bit r0, input bit r1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [3:0] l0, input logic [3:0] l1,
                         input int rlast_at, input int rst_beat);
    bit          win;
    bit          ok;
    logic [31:0] wa;
    logic [3:0]  wl;
    int          nb;
    win = (r0 && r1) ? m_pri : r1;
    wa  = win ? a1 : a0;
    wl  = win ? l1 : l0;
    nb  = (rlast_at == 0) ? int'(wl) + 1 : rlast_at;
    if (nb != int'(wl) + 1) m_err = 1'b1;

    @(posedge ACLK); #1;
    u_if.arvalid_m0_i = r0;
    u_if.araddr_m0_i  = a0;
    u_if.arlen_m0_i   = l0;
    u_if.arvalid_m1_i = r1;
    u_if.araddr_m1_i  = a1;
    u_if.arlen_m1_i   = l1;
    exp_q.push_back({m_err, ref_decode(wa), (win ? 2'b10 : 2'b01)});
    m_pri = !win;

    wait_busy(ok);
    if (!ok) begin
      clear_inputs();
      return;
    end
    // Dropping arvalid early is a master violation the scheduler must tolerate.
    if ($urandom_range(0, 1) == 1) begin
      u_if.arvalid_m0_i = 1'b0;
      u_if.arvalid_m1_i = 1'b0;
    end
    repeat ($urandom_range(0, 3)) begin
      @(posedge ACLK); #1;
    end
    u_if.arvalid_m0_i  = 1'b0;
    u_if.arvalid_m1_i  = 1'b0;
    u_if.arready_sel_i = 1'b1;
    @(posedge ACLK); #1;
    u_if.arready_sel_i = 1'b0;

    for (int b = 1; b <= nb; b++) begin
      repeat ($urandom_range(0, 2)) begin
        u_if.rvalid_sel_i = 1'($urandom_range(0, 1));
        u_if.rready_sel_i = u_if.rvalid_sel_i ? 1'b0 : 1'($urandom_range(0, 1));
        @(posedge ACLK); #1;
      end
      if (b == rst_beat) begin
        clear_inputs();
        ARESETn = 1'b0;
        #1;
        check("rst_async_grant", 32'(u_if.grant_o), 32'd0);
        check("rst_async_sel", 32'(u_if.slv_sel_o), 32'd0);
        check("rst_async_busy", 32'({u_if.busy_o, u_if.ar_en_o}), 32'd0);
        check("rst_async_len_err", 32'(u_if.len_err_o), 32'd0);
        m_pri = 1'b0;
        m_err = 1'b0;
        @(posedge ACLK); #1;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        return;
      end
      u_if.rvalid_sel_i = 1'b1;
      u_if.rready_sel_i = 1'b1;
      u_if.rlast_sel_i  = (b == nb);
      @(posedge ACLK); #1;
      u_if.rvalid_sel_i = 1'b0;
      u_if.rready_sel_i = 1'b0;
      u_if.rlast_sel_i  = 1'b0;
    end
    check("idle_after_rlast", 32'(u_if.busy_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          r0, r1;
    logic [1:0]  r;
    n_cmp   = 0;
    n_err   = 0;
    m_pri   = 1'b0;
    m_err   = 1'b0;
    ARESETn = 1'b0;
    clear_inputs();
    u_if.araddr_m0_i = 32'd0;
    u_if.araddr_m1_i = 32'd0;
    u_if.arlen_m0_i  = 4'd0;
    u_if.arlen_m1_i  = 4'd0;

    #3;
    check("reset_outputs", 32'({u_if.grant_o, u_if.slv_sel_o, u_if.ar_en_o,
                                u_if.busy_o, u_if.len_err_o, u_if.timeout_o}), 32'd0);
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    check("post_reset_idle", 32'({u_if.grant_o, u_if.slv_sel_o, u_if.busy_o}), 32'd0);

    // Continuous contention, single-beat bursts: M0, M1, M0, M1.
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 32'h0000_0010, 32'h0001_0020, 4'd0, 4'd0, 0, 0);

    run_txn(1, 0, 32'h0000_0100, 32'h0, 4'd3, 4'd0, 0, 0);
    run_txn(0, 1, 32'h0, 32'h0001_0040, 4'd0, 4'd2, 0, 0);
    run_txn(0, 1, 32'h0, 32'h0005_0000, 4'd0, 4'd1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      r  = 2'($urandom_range(1, 3));
      r0 = r[0];
      r1 = r[1];
      run_txn(r0, r1, pick_addr(), pick_addr(),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 0);
    end

    // Short burst, then a clean one (flag must stay), then a late RLAST.
    run_txn(1, 0, 32'h0000_0200, 32'h0, 4'd3, 4'd0, 2, 0);
    run_txn(0, 1, 32'h0, 32'h0001_0000, 4'd0, 4'd1, 0, 0);
    run_txn(0, 1, 32'h0, 32'h0002_0000, 4'd0, 4'd1, 3, 0);

    // Reset during beat 2 of a DATA phase, then contention must favour M0.
    run_txn(0, 1, 32'h0, 32'h0001_0010, 4'd0, 4'd3, 0, 2);
    run_txn(1, 1, 32'h0001_0000, 32'h0000_0000, 4'd1, 4'd1, 0, 0);

`ifdef AXI_RD_TIMEOUT_EN
    begin
      bit ok;
      int cyc;
      @(posedge ACLK); #1;
      u_if.arvalid_m0_i = 1'b1;
      u_if.araddr_m0_i  = 32'h0000_0000;
      u_if.arlen_m0_i   = 4'd0;
      exp_q.push_back({m_err, 3'b001, 2'b01});
      m_pri = 1'b1;
      wait_busy(ok);
      u_if.arvalid_m0_i = 1'b0;
      cyc = 1;
      for (int i = 0; i < 4 * TO_CYC; i++) begin
        @(negedge ACLK);
        if (!u_if.busy_o) break;
        cyc++;
      end
      check("timeout_addr_cycles", 32'(cyc), 32'(TO_CYC));
      check("timeout_flag", 32'(u_if.timeout_o), 32'd1);
      run_txn(1, 1, 32'h0000_0000, 32'h0001_0000, 4'd0, 4'd0, 0, 0);
      check("timeout_sticky", 32'(u_if.timeout_o), 32'd1);
    end
`else
    check("timeout_tied_low", 32'(u_if.timeout_o), 32'd0);
`endif

    repeat (3) @(posedge ACLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_rd_scheduler.md
Name: axi_rd_scheduler

Overview:
- Read-path controller for the 2-master / 2-slave AXI crossbar.
- Arbitrates AR requests from M0 and M1 using round-robin, and decodes the target (S0, S1, or default slave).
- Holds the grant and slave select stable from AR issue until the RLAST handshake.
- Drives the select lines of the AR and R channel muxes, and counts R beats against ARLEN.

Parameters:
- S0_BASE, 32'h0000_0000, S0 window base address
- S1_BASE, 32'h0001_0000, S1 window base address
- WIN_MASK, 32'hFFFF_0000, window compare mask; an address that matches neither window selects the default slave
- TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- arvalid_m0_i  in  1  M0 AR request
- araddr_m0_i  in  32  M0 AR address
- arlen_m0_i  in  4  M0 AR burst length
- arvalid_m1_i  in  1  M1 AR request
- araddr_m1_i  in  32  M1 AR address
- arlen_m1_i  in  4  M1 AR burst length
- arready_sel_i  in  1  ARREADY of the currently selected slave
- rvalid_sel_i  in  1  RVALID of the selected slave
- rready_sel_i  in  1  RREADY of the granted master
- rlast_sel_i  in  1  RLAST of the selected slave
- grant_o  out  2  one-hot master grant {m1,m0}
- slv_sel_o  out  3  one-hot slave select {sd,s1,s0}
- ar_en_o  out  1  enables AR forwarding through the mux
- busy_o  out  1  transaction in flight
- len_err_o  out  1  sticky beat-count mismatch
- timeout_o  out  1  sticky watchdog flag (tied 0 without the optional feature)

Behaviour:
- Reset (asynchronous, ARESETn=0):
  - all outputs 0; state IDLE; rr_pri=M0; beat counter 0.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If exactly one arvalid is high, grant that master.
  - If both are high, grant the master indicated by rr_pri.
  - On the grant cycle, register grant_o, slv_sel_o (decoded from the winner's address) and arlen.
  - Move to ADDR on the next cycle. Arbitration latency is 1 cycle; no grant in the same cycle as the request.
- ADDR:
  - ar_en_o=1.
  - When arready_sel_i=1, go to DATA and clear ar_en_o the next cycle.
  - grant_o and slv_sel_o are held stable throughout.
- DATA:
  - ar_en_o=0.
  - Each cycle with rvalid_sel_i & rready_sel_i increments beat_cnt (5 bits).
  - On a handshake with rlast_sel_i=1, compare beat_cnt+1 against arlen+1; on mismatch set len_err_o.
  - Then: beat_cnt←0, grant_o←0, slv_sel_o←0, toggle rr_pri to the master not just served, go to IDLE.
  - If beat_cnt reaches arlen+1 without rlast, set len_err_o and keep waiting for rlast.
- busy_o=1 in ADDR and DATA.
- Fairness: under continuous requests from both masters, grants alternate M0, M1, M0...
- Decode priority: S0 window, then S1 window, then default. Exactly one bit of slv_sel_o is high whenever grant_o≠0.
- arvalid deasserting while in ADDR is a master protocol violation. The scheduler ignores it and stays in ADDR.
- Mid-operation reset returns to IDLE asynchronously and clears the sticky flags.
- Only one outstanding read at a time. New requests wait in IDLE.

Optional Feature:
- Macro: AXI_RD_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in ADDR and DATA and clears on every handshake.
  - On reaching TIMEOUT_CYCLES: set timeout_o (sticky), force state to IDLE, clear grant and select, toggle rr_pri.
- When undefined:
  - No counter logic; timeout_o is tied 0; the scheduler waits indefinitely.

Test Plan:
- M0 only, araddr=0x0000_0100, arlen=3, slave ready immediately, 4 beats with rlast on the 4th -> grant_o=01, slv_sel_o=001; back to IDLE one cycle after the last handshake; len_err_o=0.
- M0 and M1 request together continuously, both arlen=0 -> grant order M0, M1, M0, M1 across 4 transactions.
- M1 araddr=0x0001_0040 -> slv_sel_o=010; araddr=0x0005_0000 -> slv_sel_o=100 (default slave).
- arlen=3 but rlast arrives on beat 2 -> len_err_o=1 and stays set; state returns to IDLE.
- ARESETn pulsed low during DATA beat 2 -> all outputs 0 immediately; next request is arbitrated from M0 priority.
- With AXI_RD_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never raises arready -> timeout_o=1 after 16 cycles in ADDR; grant cleared; the other master is served next.
